// File: rtl/bram_test_sequencer.sv
// Block RAM exerciser: write pattern, read back, compare, wait, repeat inverted.
// Optional BRAM_TEST_ERR_INJECT_EN adds inject_i to corrupt bit 0 of written words.
module bram_test_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
`ifdef BRAM_TEST_ERR_INJECT_EN
  input  logic                  inject_i,
`endif
  input  logic                  timed_out_i,
  output logic                  timer_reset_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  busy_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic [15:0]           error_count_o,
  output logic [ADDR_WIDTH-1:0] first_fail_addr_o,
  output logic [15:0]           run_count_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_WAIT
  } state_t;

  state_t r_state, w_state_nxt;

  logic                  r_invert, w_invert_nxt;
  logic                  r_wait_arm, w_wait_arm_nxt;
  logic                  r_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                  r_timer_rst, w_timer_rst_nxt;
  logic                  r_busy, w_busy_nxt;
  logic [15:0]           r_run, w_run_nxt;
  logic                  r_pass, w_pass_nxt;

  logic                  r_cmp_vld, w_cmp_vld_nxt;
  logic [DATA_WIDTH-1:0] r_cmp_exp, w_cmp_exp_nxt;
  logic [ADDR_WIDTH-1:0] r_cmp_addr, w_cmp_addr_nxt;

  logic                  r_fail, w_fail_nxt;
  logic [15:0]           r_err_cnt, w_err_nxt;
  logic [ADDR_WIDTH-1:0] r_ffa, w_ffa_nxt;

  logic                  w_mismatch;
  logic                  w_inject;
  logic [ADDR_WIDTH-1:0] w_addr_inc;

  function automatic logic [DATA_WIDTH-1:0] pat(
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  inv
  );
    pat = DATA_WIDTH'(a) ^ {DATA_WIDTH{inv}};
  endfunction

`ifdef BRAM_TEST_ERR_INJECT_EN
  assign w_inject = inject_i;
`else
  assign w_inject = 1'b0;
`endif

  assign w_addr_inc = r_addr + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_invert_nxt    = r_invert;
    w_wait_arm_nxt  = 1'b0;
    w_we_nxt        = 1'b0;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_timer_rst_nxt = 1'b1;
    w_busy_nxt      = 1'b0;
    w_run_nxt       = r_run;
    w_cmp_vld_nxt   = 1'b0;
    w_cmp_exp_nxt   = r_cmp_exp;
    w_cmp_addr_nxt  = r_cmp_addr;
    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_WRITE;
        w_we_nxt    = 1'b1;
        w_busy_nxt  = 1'b1;
        w_addr_nxt  = '0;
        w_wdata_nxt = pat('0, r_invert);
      end
      S_WRITE: begin
        w_busy_nxt = 1'b1;
        if (r_addr == LAST) begin
          w_state_nxt = S_READ;
          w_addr_nxt  = '0;
        end else begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = w_addr_inc;
          w_wdata_nxt = pat(w_addr_inc, r_invert)
                      ^ DATA_WIDTH'(w_inject);
        end
      end
      S_READ: begin
        w_busy_nxt     = 1'b1;
        w_cmp_vld_nxt  = 1'b1;
        w_cmp_exp_nxt  = pat(r_addr, r_invert);
        w_cmp_addr_nxt = r_addr;
        if (r_addr == LAST) begin
          w_state_nxt = S_DRAIN;
          w_addr_nxt  = '0;
        end else begin
          w_addr_nxt = w_addr_inc;
        end
      end
      S_DRAIN: begin
        w_state_nxt     = S_WAIT;
        w_run_nxt       = r_run + 16'd1;
        w_timer_rst_nxt = 1'b0;
        w_wait_arm_nxt  = 1'b1;
      end
      S_WAIT: begin
        w_timer_rst_nxt = 1'b0;
        // first WAIT cycle still sees the timer's pre-reset flag
        if (!r_wait_arm && timed_out_i) begin
          w_state_nxt     = S_WRITE;
          w_invert_nxt    = ~r_invert;
          w_we_nxt        = 1'b1;
          w_busy_nxt      = 1'b1;
          w_addr_nxt      = '0;
          w_wdata_nxt     = pat('0, ~r_invert);
          w_timer_rst_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_mismatch = r_cmp_vld && (ram_rdata_i != r_cmp_exp);
    w_err_nxt  = r_err_cnt;
    w_ffa_nxt  = r_ffa;
    if (w_mismatch && (r_err_cnt != 16'hFFFF))
      w_err_nxt = r_err_cnt + 16'd1;
    if (w_mismatch && !r_fail)
      w_ffa_nxt = r_cmp_addr;
    w_fail_nxt = r_fail | w_mismatch;
    w_pass_nxt = (w_run_nxt != 16'd0) && !w_fail_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_invert    <= 1'b0;
      r_wait_arm  <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_timer_rst <= 1'b1;
      r_busy      <= 1'b0;
      r_run       <= '0;
      r_pass      <= 1'b0;
      r_cmp_vld   <= 1'b0;
      r_cmp_exp   <= '0;
      r_cmp_addr  <= '0;
      r_fail      <= 1'b0;
      r_err_cnt   <= '0;
      r_ffa       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_invert    <= w_invert_nxt;
      r_wait_arm  <= w_wait_arm_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_timer_rst <= w_timer_rst_nxt;
      r_busy      <= w_busy_nxt;
      r_run       <= w_run_nxt;
      r_pass      <= w_pass_nxt;
      r_cmp_vld   <= w_cmp_vld_nxt;
      r_cmp_exp   <= w_cmp_exp_nxt;
      r_cmp_addr  <= w_cmp_addr_nxt;
      r_fail      <= w_fail_nxt;
      r_err_cnt   <= w_err_nxt;
      r_ffa       <= w_ffa_nxt;
    end
  end

  assign timer_reset_o     = r_timer_rst;
  assign ram_we_o          = r_we;
  assign ram_addr_o        = r_addr;
  assign ram_wdata_o       = r_wdata;
  assign busy_o            = r_busy;
  assign pass_o            = r_pass;
  assign fail_o            = r_fail;
  assign error_count_o     = r_err_cnt;
  assign first_fail_addr_o = r_ffa;
  assign run_count_o       = r_run;

endmodule

// File: tb/tb_bram_test_sequencer.sv
// Directed bench for bram_test_sequencer with RAM and timeout-timer models.
// Inject scenario runs only when BRAM_TEST_ERR_INJECT_EN is defined.
module tb_bram_test_sequencer;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       timed_out_i;
  logic       timer_reset_o;
  logic       ram_we_o;
  logic [3:0] ram_addr_o;
  logic [7:0] ram_wdata_o;
  logic [7:0] ram_rdata_i;
  logic       busy_o;
  logic       pass_o;
  logic       fail_o;
  logic [15:0] error_count_o;
  logic [3:0] first_fail_addr_o;
  logic [15:0] run_count_o;
`ifdef BRAM_TEST_ERR_INJECT_EN
  logic       inject_i;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  mem [16];
  logic [15:0] bad;
  logic [15:0] inj;
  logic [5:0]  tcnt = '0;
  logic        force_to;

  int          e_err;
  logic        e_fail;
  logic [3:0]  e_ffa;
  logic [15:0] e_run;
  logic        e_inv;
  int          n_wait;

  bram_test_sequencer #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
`ifdef BRAM_TEST_ERR_INJECT_EN
    .inject_i         (inject_i),
`endif
    .timed_out_i      (timed_out_i),
    .timer_reset_o    (timer_reset_o),
    .ram_we_o         (ram_we_o),
    .ram_addr_o       (ram_addr_o),
    .ram_wdata_o      (ram_wdata_o),
    .ram_rdata_i      (ram_rdata_i),
    .busy_o           (busy_o),
    .pass_o           (pass_o),
    .fail_o           (fail_o),
    .error_count_o    (error_count_o),
    .first_fail_addr_o(first_fail_addr_o),
    .run_count_o      (run_count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_o === 1'b1) mem[ram_addr_o] <= ram_wdata_o;
    ram_rdata_i <= mem[ram_addr_o] ^ {7'd0, bad[ram_addr_o]};
  end

  always @(posedge clk) begin
    if (timer_reset_o !== 1'b0) tcnt <= '0;
    else if (tcnt < 6'd20) tcnt <= tcnt + 6'd1;
  end
  assign timed_out_i = force_to | (tcnt == 6'd20);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] epat(input int a, input logic inv);
    return 8'(a) ^ {8{inv}};
  endfunction

  task automatic apply_cmp(input int a);
    if (bad[a] | inj[a]) begin
      if (e_err < 65535) e_err++;
      if (!e_fail) begin
        e_fail = 1'b1;
        e_ffa  = 4'(a);
      end
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_err"},  error_count_o, e_err);
    chk({tag, "_fail"}, fail_o, e_fail);
    chk({tag, "_ffa"},  first_fail_addr_o, e_ffa);
    chk({tag, "_pass"}, pass_o, (e_run != 0) && !e_fail);
    chk({tag, "_run"},  run_count_o, e_run);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we"},    ram_we_o, 0);
    chk({tag, "_addr"},  ram_addr_o, 0);
    chk({tag, "_wdata"}, ram_wdata_o, 0);
    chk({tag, "_trst"},  timer_reset_o, 1);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_pass"},  pass_o, 0);
    chk({tag, "_fail"},  fail_o, 0);
    chk({tag, "_err"},   error_count_o, 0);
    chk({tag, "_ffa"},   first_fail_addr_o, 0);
    chk({tag, "_run"},   run_count_o, 0);
  endtask

  // Entered at the negedge showing the write of address 0.
  task automatic do_pass(input int reset_at, input bit force_sat);
    for (int i = 0; i < 16; i++) begin
      chk("wr_we",   ram_we_o, 1);
      chk("wr_addr", ram_addr_o, i);
      chk("wr_data", ram_wdata_o, epat(i, e_inv) ^ {7'd0, inj[i]});
      chk("wr_busy", busy_o, 1);
`ifdef BRAM_TEST_ERR_INJECT_EN
      inject_i = (i < 15) ? inj[i+1] : 1'b0;
`endif
      if (force_sat && i == 0) force dut.r_err_cnt = 16'hFFFE;
      @(negedge clk);
      if (force_sat && i == 0) begin
        release dut.r_err_cnt;
        e_err = 65534;
      end
    end
    for (int i = 0; i < 16; i++) begin
      chk("rd_we",   ram_we_o, 0);
      chk("rd_addr", ram_addr_o, i);
      if (i >= 2) apply_cmp(i - 2);
      chk_status("rd");
      if (i == reset_at) begin
        reset_i = 1'b1;
        @(posedge clk);
        #1 reset_i = 1'b0;
        e_err = 0; e_fail = 1'b0; e_ffa = '0;
        e_run = '0; e_inv = 1'b0;
        @(negedge clk);
        chk_reset("midrst");
        @(negedge clk);
        chk("restart_we",    ram_we_o, 1);
        chk("restart_addr",  ram_addr_o, 0);
        chk("restart_wdata", ram_wdata_o, 8'h00);
        chk("restart_fail",  fail_o, 0);
        chk("restart_err",   error_count_o, 0);
        return;
      end
      @(negedge clk);
    end
    chk("drain_busy", busy_o, 1);
    chk("drain_trst", timer_reset_o, 1);
    apply_cmp(14);
    chk_status("drain");
    @(negedge clk);
    apply_cmp(15);
    e_run++;
    chk("wait_trst", timer_reset_o, 0);
    chk("wait_busy", busy_o, 0);
    chk_status("wait");
    e_inv = ~e_inv;
  endtask

  task automatic wait_write0(output int ncyc);
    ncyc = 0;
    while (!(ram_we_o === 1'b1 && ram_addr_o == 4'd0) && ncyc < 200) begin
      ncyc++;
      @(negedge clk);
    end
    chk("wait_bound", ncyc < 200, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    reset_i  = 1'b1;
    force_to = 1'b0;
    bad      = '0;
    inj      = '0;
    e_err = 0; e_fail = 1'b0; e_ffa = '0;
    e_run = '0; e_inv = 1'b0;
`ifdef BRAM_TEST_ERR_INJECT_EN
    inject_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk_reset("rst");
    @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    chk("idle_we",   ram_we_o, 0);
    chk("idle_trst", timer_reset_o, 1);
    @(negedge clk);

    do_pass(-1, 1'b0);
    wait_write0(n_wait);
    chk("wait_len_timer", n_wait, 21);

    do_pass(-1, 1'b0);
    wait_write0(n_wait);

    bad = 16'h0080;
    do_pass(-1, 1'b0);
    bad = '0;
    wait_write0(n_wait);

    do_pass(-1, 1'b0);
    wait_write0(n_wait);

    force_to = 1'b1;
    do_pass(-1, 1'b0);
    wait_write0(n_wait);
    chk("wait_len_forced", n_wait, 2);

    bad = 16'h0824;
    do_pass(-1, 1'b1);
    bad = '0;
    chk("sat_err", error_count_o, 16'hFFFF);
    wait_write0(n_wait);

    do_pass(-1, 1'b0);
    wait_write0(n_wait);

    bad = 16'h0100;
    do_pass(9, 1'b0);
    bad = '0;

`ifdef BRAM_TEST_ERR_INJECT_EN
    inj = 16'h0008;
`endif
    do_pass(-1, 1'b0);
    inj = '0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
